// File: rtl/othello_pkg.sv
// othello_pkg -- shared definitions for the Othello move controller.
//   Cell codes, controller state enumeration, direction deltas (index 0..7 =
//   N, NE, E, SE, S, SW, W, NW; row grows southward, column grows eastward),
//   the opening board and a cell bit-offset helper.
//   Optional build macro used by the controller: OTHELLO_HINT_EN.
package othello_pkg;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_A     = 2'b01;
   localparam logic [1:0] CELL_B     = 2'b10;
   localparam logic [1:0] CELL_HINT  = 2'b11;

   typedef enum logic [3:0] {
      S_IDLE,
      S_RECOUNT,
      S_CHECK,
      S_SCAN,
      S_FLIP,
      S_NEXTDIR,
      S_COMMIT,
      S_HINT,
      S_DONE
   } state_e;

   localparam logic [2:0] DIR_N  = 3'd0;
   localparam logic [2:0] DIR_NW = 3'd7;

   // Two's-complement deltas: 2'b11 = -1, 2'b00 = 0, 2'b01 = +1.
   localparam logic [1:0] DIR_DR [8] = '{2'b11, 2'b11, 2'b00, 2'b01,
                                          2'b01, 2'b01, 2'b00, 2'b11};
   localparam logic [1:0] DIR_DC [8] = '{2'b00, 2'b01, 2'b01, 2'b01,
                                          2'b00, 2'b11, 2'b11, 2'b11};

   // (3,3)=B, (4,4)=B, (3,4)=A, (4,3)=A
   localparam logic [127:0] INIT_BOARD = (128'h2 << 54) | (128'h1 << 56) |
                                         (128'h1 << 70) | (128'h2 << 72);

   // LSB position of cell (row,col) inside the 128-bit board vector.
   function automatic logic [6:0] cell_lsb(input logic [2:0] row, input logic [2:0] col);
      return {row, col, 1'b0};
   endfunction

endpackage

// File: rtl/othello_step.sv
// othello_step -- combinational one-cell step on the 8x8 board.
//   row_i, col_i : current cell
//   dir_i        : direction 0..7 (N clockwise to NW)
//   row_o, col_o : neighbouring cell (meaningless when off_o=1)
//   off_o        : neighbour lies outside the board; no wrap-around
module othello_step
   import othello_pkg::*;
(
   input  logic [2:0] row_i,
   input  logic [2:0] col_i,
   input  logic [2:0] dir_i,
   output logic [2:0] row_o,
   output logic [2:0] col_o,
   output logic       off_o
);

   logic [1:0] dr;
   logic [1:0] dc;
   logic [4:0] r_sum;
   logic [4:0] c_sum;

   // Five-bit sums: -1 shows up as 5'b11111 and 8 as 5'b01000, so any set
   // bit in [4:3] means the step left the 0..7 range.
   always_comb begin
      dr    = DIR_DR[dir_i];
      dc    = DIR_DC[dir_i];
      r_sum = {2'b00, row_i} + {{3{dr[1]}}, dr};
      c_sum = {2'b00, col_i} + {{3{dc[1]}}, dc};
      row_o = r_sum[2:0];
      col_o = c_sum[2:0];
      off_o = (r_sum[4:3] != 2'b00) || (c_sum[4:3] != 2'b00);
   end

endmodule

// File: rtl/othello_move_ctrl.sv
// othello_move_ctrl -- sequential Othello move engine.
//   clk, rst_n          : clock, asynchronous active-low reset
//   mv_valid/mv_ready   : move handshake; mv_row/mv_col sampled on acceptance
//   mv_done, mv_legal   : one-cycle completion pulse and its result
//   ld_en, ld_field     : board preload (honoured only in IDLE), then recount
//   field_o             : board, cell (r,c) at bits [2*(8r+c)+1 : 2*(8r+c)]
//   turn_o              : side to move, 0 = code 01, 1 = code 10
//   score01, score10    : piece counts
//   Macro OTHELLO_HINT_EN: after a legal move, mark empty neighbours of the
//   target with code 11 (one direction per cycle).
//
// state   | meaning
// IDLE    | ready for a move or a preload
// RECOUNT | rebuild scores from the board, two cells per cycle
// CHECK   | reject an occupied target, else start direction N
// SCAN    | walk outward one cell per cycle counting opponent pieces
// FLIP    | walk back toward the target recolouring the run
// NEXTDIR | advance to the next direction or finish
// COMMIT  | place the piece, update scores and turn if anything flipped
// HINT    | mark empty neighbours with code 11 (OTHELLO_HINT_EN only)
// DONE    | pulse mv_done with the result
module othello_move_ctrl
   import othello_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         mv_valid,
   output logic         mv_ready,
   input  logic [2:0]   mv_row,
   input  logic [2:0]   mv_col,
   output logic         mv_done,
   output logic         mv_legal,
   input  logic         ld_en,
   input  logic [127:0] ld_field,
   output logic [127:0] field_o,
   output logic         turn_o,
   output logic [6:0]   score01,
   output logic [6:0]   score10
);

   state_e       state_q, state_d;
   logic [127:0] field_q, field_d;
   logic         turn_q, turn_d;
   logic [6:0]   s01_q, s01_d;
   logic [6:0]   s10_q, s10_d;
   logic [2:0]   tgt_row_q, tgt_row_d;
   logic [2:0]   tgt_col_q, tgt_col_d;
   logic [2:0]   cur_row_q, cur_row_d;
   logic [2:0]   cur_col_q, cur_col_d;
   logic [2:0]   dir_q, dir_d;
   logic [2:0]   run_q, run_d;
   logic [4:0]   flips_q, flips_d;
   logic         legal_q, legal_d;
   logic [4:0]   cnt_q, cnt_d;

   logic [2:0]   st_dir;
   logic [2:0]   nx_row;
   logic [2:0]   nx_col;
   logic         nx_off;
   logic [1:0]   nx_cell;
   logic [1:0]   tgt_cell;
   logic [1:0]   mover;
   logic [1:0]   opp;
   logic [1:0]   rc_lo;
   logic [1:0]   rc_hi;

   // FLIP walks back toward the target: the opposite direction is dir+4.
   assign st_dir = (state_q == S_FLIP) ? dir_q + 3'd4 : dir_q;

   othello_step u_step (
      .row_i (cur_row_q),
      .col_i (cur_col_q),
      .dir_i (st_dir),
      .row_o (nx_row),
      .col_o (nx_col),
      .off_o (nx_off)
   );

   assign nx_cell  = field_q[cell_lsb(nx_row, nx_col) +: 2];
   assign tgt_cell = field_q[cell_lsb(tgt_row_q, tgt_col_q) +: 2];
   assign mover    = turn_q ? CELL_B : CELL_A;
   assign opp      = turn_q ? CELL_A : CELL_B;
   assign rc_lo    = field_q[{cnt_q, 2'b00} +: 2];
   assign rc_hi    = field_q[{cnt_q, 2'b10} +: 2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         field_q   <= INIT_BOARD;
         turn_q    <= 1'b0;
         s01_q     <= 7'd2;
         s10_q     <= 7'd2;
         tgt_row_q <= '0;
         tgt_col_q <= '0;
         cur_row_q <= '0;
         cur_col_q <= '0;
         dir_q     <= '0;
         run_q     <= '0;
         flips_q   <= '0;
         legal_q   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         field_q   <= field_d;
         turn_q    <= turn_d;
         s01_q     <= s01_d;
         s10_q     <= s10_d;
         tgt_row_q <= tgt_row_d;
         tgt_col_q <= tgt_col_d;
         cur_row_q <= cur_row_d;
         cur_col_q <= cur_col_d;
         dir_q     <= dir_d;
         run_q     <= run_d;
         flips_q   <= flips_d;
         legal_q   <= legal_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      field_d   = field_q;
      turn_d    = turn_q;
      s01_d     = s01_q;
      s10_d     = s10_q;
      tgt_row_d = tgt_row_q;
      tgt_col_d = tgt_col_q;
      cur_row_d = cur_row_q;
      cur_col_d = cur_col_q;
      dir_d     = dir_q;
      run_d     = run_q;
      flips_d   = flips_q;
      legal_d   = legal_q;
      cnt_d     = cnt_q;

      case (state_q)
         S_IDLE: begin
            // A preload wins over a simultaneous move request.
            if (ld_en) begin
               field_d = ld_field;
               s01_d   = '0;
               s10_d   = '0;
               cnt_d   = 5'd31;
               state_d = S_RECOUNT;
            end else if (mv_valid) begin
               tgt_row_d = mv_row;
               tgt_col_d = mv_col;
               state_d   = S_CHECK;
            end
         end

         S_RECOUNT: begin
            s01_d = s01_q + {6'd0, rc_lo == CELL_A} + {6'd0, rc_hi == CELL_A};
            s10_d = s10_q + {6'd0, rc_lo == CELL_B} + {6'd0, rc_hi == CELL_B};
            if (cnt_q == 5'd0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end

         S_CHECK: begin
            legal_d = 1'b0;
            if (tgt_cell != CELL_EMPTY && tgt_cell != CELL_HINT) begin
               state_d = S_DONE;
            end else begin
               cur_row_d = tgt_row_q;
               cur_col_d = tgt_col_q;
               dir_d     = DIR_N;
               run_d     = '0;
               flips_d   = '0;
               state_d   = S_SCAN;
            end
         end

         S_SCAN: begin
            if (nx_off) begin
               state_d = S_NEXTDIR;
            end else if (nx_cell == opp) begin
               run_d     = run_q + 3'd1;
               cur_row_d = nx_row;
               cur_col_d = nx_col;
            end else if (nx_cell == mover && run_q != 3'd0) begin
               // Park on the bracketing piece; FLIP steps back from here.
               cur_row_d = nx_row;
               cur_col_d = nx_col;
               state_d   = S_FLIP;
            end else begin
               state_d = S_NEXTDIR;
            end
         end

         S_FLIP: begin
            field_d[cell_lsb(nx_row, nx_col) +: 2] = mover;
            cur_row_d = nx_row;
            cur_col_d = nx_col;
            run_d     = run_q - 3'd1;
            flips_d   = flips_q + 5'd1;
            if (run_q == 3'd1) begin
               state_d = S_NEXTDIR;
            end
         end

         S_NEXTDIR: begin
            if (dir_q == DIR_NW) begin
               state_d = S_COMMIT;
            end else begin
               dir_d     = dir_q + 3'd1;
               cur_row_d = tgt_row_q;
               cur_col_d = tgt_col_q;
               run_d     = '0;
               state_d   = S_SCAN;
            end
         end

         S_COMMIT: begin
            cur_row_d = tgt_row_q;
            cur_col_d = tgt_col_q;
            state_d   = S_DONE;
            if (flips_q != 5'd0) begin
               field_d[cell_lsb(tgt_row_q, tgt_col_q) +: 2] = mover;
               if (turn_q) begin
                  s10_d = s10_q + {2'b00, flips_q} + 7'd1;
                  s01_d = s01_q - {2'b00, flips_q};
               end else begin
                  s01_d = s01_q + {2'b00, flips_q} + 7'd1;
                  s10_d = s10_q - {2'b00, flips_q};
               end
               turn_d  = ~turn_q;
               legal_d = 1'b1;
`ifdef OTHELLO_HINT_EN
               dir_d   = DIR_N;
               state_d = S_HINT;
`endif
            end
         end

`ifdef OTHELLO_HINT_EN
         S_HINT: begin
            if (!nx_off && nx_cell == CELL_EMPTY) begin
               field_d[cell_lsb(nx_row, nx_col) +: 2] = CELL_HINT;
            end
            if (dir_q == DIR_NW) begin
               state_d = S_DONE;
            end else begin
               dir_d = dir_q + 3'd1;
            end
         end
`endif

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign mv_ready = (state_q == S_IDLE);
   assign mv_done  = (state_q == S_DONE);
   assign mv_legal = (state_q == S_DONE) && legal_q;
   assign field_o  = field_q;
   assign turn_o   = turn_q;
   assign score01  = s01_q;
   assign score10  = s10_q;

endmodule

// File: tb/tb_othello_move_ctrl.sv
// tb_othello_move_ctrl -- directed, table-driven bench for othello_move_ctrl
// (default build, OTHELLO_HINT_EN undefined).
module tb_othello_move_ctrl;
   import othello_pkg::*;

   logic         clk;
   logic         rst_n;
   logic         mv_valid;
   logic         mv_ready;
   logic [2:0]   mv_row;
   logic [2:0]   mv_col;
   logic         mv_done;
   logic         mv_legal;
   logic         ld_en;
   logic [127:0] ld_field;
   logic [127:0] field_o;
   logic         turn_o;
   logic [6:0]   score01;
   logic [6:0]   score10;

   int errors = 0;
   int checks = 0;

   othello_move_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .mv_valid (mv_valid),
      .mv_ready (mv_ready),
      .mv_row   (mv_row),
      .mv_col   (mv_col),
      .mv_done  (mv_done),
      .mv_legal (mv_legal),
      .ld_en    (ld_en),
      .ld_field (ld_field),
      .field_o  (field_o),
      .turn_o   (turn_o),
      .score01  (score01),
      .score10  (score10)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         pre;
      logic [127:0] board;
      logic [2:0]   r;
      logic [2:0]   c;
      logic         legal;
      logic [127:0] exp_board;
      int           s01;
      int           s10;
      logic         turn;
      int           max_lat;
   } vec_t;

   localparam int NV = 8;
   vec_t vecs[NV];

   function automatic logic [127:0] setc(input logic [127:0] b, input int r, input int c,
                                         input logic [1:0] v);
      logic [127:0] t;
      t = b;
      t[2*(8*r+c) +: 2] = v;
      return t;
   endfunction

   function automatic vec_t mk(input logic pre, input logic [127:0] b, input logic [2:0] r,
                               input logic [2:0] c, input logic lg, input logic [127:0] eb,
                               input int a, input int bb, input logic t, input int ml);
      vec_t v;
      v.pre = pre; v.board = b; v.r = r; v.c = c; v.legal = lg; v.exp_board = eb;
      v.s01 = a; v.s10 = bb; v.turn = t; v.max_lat = ml;
      return v;
   endfunction

   task automatic chk_bit(input string nm, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", nm, got, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic chk_board(input string nm, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %032h expected %032h", nm, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic do_load(input logic [127:0] b);
      int n;
      n = -1;
      @(negedge clk);
      ld_field = b;
      ld_en    = 1'b1;
      @(posedge clk); #1;
      ld_en = 1'b0;
      for (int i = 1; i <= 80; i++) begin
         @(negedge clk);
         if (mv_ready) begin
            n = i;
            break;
         end
      end
      // not ready right after the load, ready again within 64 cycles
      chk_bit("recount_window", (n >= 2) && (n <= 64), 1'b1);
   endtask

   // Presents a move, then scrambles the coordinates and pulses ld_en while
   // the controller is busy; both must be ignored.
   task automatic do_move(input logic [2:0] r, input logic [2:0] c, output int lat,
                          output logic lg, output logic done_after);
      lat        = -1;
      lg         = 1'b0;
      done_after = 1'b0;
      @(negedge clk);
      chk_bit("ready_before_move", mv_ready, 1'b1);
      mv_row   = r;
      mv_col   = c;
      mv_valid = 1'b1;
      @(posedge clk); #1;
      mv_row   = 3'd7;
      mv_col   = 3'd7;
      ld_field = '0;
      ld_en    = 1'b1;
      @(posedge clk); #1;
      mv_valid = 1'b0;
      ld_en    = 1'b0;
      for (int i = 1; i <= 140; i++) begin
         @(negedge clk);
         if (mv_done) begin
            lat = i;
            lg  = mv_legal;
            @(negedge clk);
            done_after = mv_done;
            break;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] init_b, b_wrap, b_multi, b_edge, b_diag, b_hint;
      logic [127:0] e0, e_multi, e_diag, e_p10;
      int           lat, n, pulses;
      logic         lg, da;

      rst_n    = 1'b0;
      mv_valid = 1'b0;
      mv_row   = '0;
      mv_col   = '0;
      ld_en    = 1'b0;
      ld_field = '0;

      init_b = setc(setc(setc(setc('0, 3, 3, 2'b10), 4, 4, 2'b10), 3, 4, 2'b01), 4, 3, 2'b01);
      e0     = setc(setc(init_b, 2, 3, 2'b01), 3, 3, 2'b01);

      b_wrap = setc(setc(setc('0, 3, 7, 2'b10), 4, 0, 2'b01), 3, 6, 2'b00);

      b_multi = setc(setc(setc(setc('0, 4, 2, 2'b10), 3, 2, 2'b10), 2, 2, 2'b10), 1, 2, 2'b01);
      b_multi = setc(setc(setc(b_multi, 5, 3, 2'b10), 5, 4, 2'b10), 5, 5, 2'b01);
      e_multi = setc(setc(setc(b_multi, 5, 2, 2'b01), 4, 2, 2'b01), 3, 2, 2'b01);
      e_multi = setc(setc(setc(e_multi, 2, 2, 2'b01), 5, 3, 2'b01), 5, 4, 2'b01);

      b_edge = '0;
      for (int k = 1; k < 8; k++) b_edge = setc(b_edge, 0, k, 2'b10);

      b_diag = setc(setc(setc('0, 1, 1, 2'b10), 2, 2, 2'b10), 3, 3, 2'b01);
      e_diag = setc(setc(setc(b_diag, 0, 0, 2'b01), 1, 1, 2'b01), 2, 2, 2'b01);

      b_hint = setc(init_b, 2, 3, 2'b11);

      e_p10 = setc(setc(init_b, 2, 3, 2'b01), 2, 2, 2'b10);

      //            pre board    r  c  legal exp_board s01 s10 turn max_lat
      vecs[0] = mk(0, '0,       2, 3, 1, e0,      4, 1, 1, 128);
      vecs[1] = mk(0, '0,       0, 0, 0, init_b,  2, 2, 0, 128);
      vecs[2] = mk(0, '0,       3, 3, 0, init_b,  2, 2, 0, 3);
      vecs[3] = mk(1, b_wrap,   3, 6, 0, b_wrap,  1, 1, 0, 128);
      vecs[4] = mk(1, b_multi,  5, 2, 1, e_multi, 8, 0, 1, 128);
      vecs[5] = mk(1, b_edge,   0, 0, 0, b_edge,  0, 7, 0, 128);
      vecs[6] = mk(1, b_diag,   0, 0, 1, e_diag,  4, 0, 1, 128);
      vecs[7] = mk(1, b_hint,   2, 3, 1, e0,      4, 1, 1, 128);

      // reset state
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_board("reset_field", field_o, init_b);
      chk_int("reset_score01", int'(score01), 2);
      chk_int("reset_score10", int'(score10), 2);
      chk_bit("reset_turn", turn_o, 1'b0);
      chk_bit("reset_ready", mv_ready, 1'b1);
      chk_bit("reset_done", mv_done, 1'b0);
      chk_bit("reset_legal", mv_legal, 1'b0);

      for (int k = 0; k < NV; k++) begin
         do_reset();
         if (vecs[k].pre) do_load(vecs[k].board);
         do_move(vecs[k].r, vecs[k].c, lat, lg, da);
         chk_bit($sformatf("v%0d_done_latency(lat=%0d)", k, lat),
                 (lat >= 1) && (lat <= vecs[k].max_lat), 1'b1);
         chk_bit($sformatf("v%0d_legal", k), lg, vecs[k].legal);
         chk_bit($sformatf("v%0d_done_one_cycle", k), da, 1'b0);
         chk_board($sformatf("v%0d_field", k), field_o, vecs[k].exp_board);
         chk_int($sformatf("v%0d_score01", k), int'(score01), vecs[k].s01);
         chk_int($sformatf("v%0d_score10", k), int'(score10), vecs[k].s10);
         chk_bit($sformatf("v%0d_turn", k), turn_o, vecs[k].turn);
      end

      // two consecutive moves: player 10 answers and flips (3,3) back
      do_reset();
      do_move(3'd2, 3'd3, lat, lg, da);
      chk_bit("p01_first_legal", lg, 1'b1);
      do_move(3'd2, 3'd2, lat, lg, da);
      chk_bit("p10_done_seen", (lat >= 1) && (lat <= 128), 1'b1);
      chk_bit("p10_legal", lg, 1'b1);
      chk_board("p10_field", field_o, e_p10);
      chk_int("p10_score01", int'(score01), 3);
      chk_int("p10_score10", int'(score10), 3);
      chk_bit("p10_turn", turn_o, 1'b0);

      // reset while recolouring a three-cell run
      do_reset();
      do_load(b_multi);
      @(negedge clk);
      mv_row   = 3'd5;
      mv_col   = 3'd2;
      mv_valid = 1'b1;
      @(posedge clk); #1;
      mv_valid = 1'b0;
      n = -1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (dut.state_q == S_FLIP) begin
            n = i;
            break;
         end
      end
      chk_bit("midflip_reached", n > 0, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_board("midflip_field_in_reset", field_o, init_b);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (mv_done) pulses++;
      end
      chk_int("midflip_no_done_pulse", pulses, 0);
      chk_board("midflip_field", field_o, init_b);
      chk_int("midflip_score01", int'(score01), 2);
      chk_int("midflip_score10", int'(score10), 2);
      chk_bit("midflip_turn", turn_o, 1'b0);
      chk_bit("midflip_ready", mv_ready, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
